// File: rtl/capp_pkg.sv
// capp_pkg: shared constants, match-line pair offsets and FSM states for the CAPP word array
package capp_pkg;
    localparam int CAPP_WIDTH = 32;
    localparam int CAPP_WORDS = 16;
    localparam int CAPP_IDX_W = $clog2(CAPP_WORDS);
    localparam int ML_ONE     = 0;
    localparam int ML_ZERO    = 1;
    typedef enum logic [1:0] {IDLE, COMPARE, RESP} state_t;
endpackage

// File: rtl/capp_priority_encoder.sv
// capp_priority_encoder: lowest set index, any-set and exactly-one-set flags of a vector
// Ports: i_vec (N-bit input), o_idx (lowest set index, 0 if none), o_any, o_single
module capp_priority_encoder #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic             o_single
);
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (i_vec[i]) o_idx = IDX_W'(i);
    end
    assign o_any    = |i_vec;
    // clearing the lowest set bit leaves nothing exactly when one bit was set
    assign o_single = o_any && ((i_vec & (i_vec - N'(1))) == '0);
endmodule

// File: rtl/capp_word_array.sv
// capp_word_array: word store that compares all words against latched match lines and streams responders
// Ports: i_clk, i_rst_n (sync, active low); search: i_match_lines, i_search_valid, o_search_ready;
//        write: i_wr_en, i_wr_addr, i_wr_data, o_wr_ready; response: o_rsp_valid, i_rsp_ready,
//        o_rsp_hit, o_rsp_index, o_rsp_data, o_rsp_last, o_rsp_count
module capp_word_array
    import capp_pkg::*;
#(
    parameter int WIDTH = CAPP_WIDTH,
    parameter int WORDS = CAPP_WORDS,
    parameter int IDX_W = CAPP_IDX_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [2*WIDTH-1:0] i_match_lines,
    input  logic               i_search_valid,
    output logic               o_search_ready,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_addr,
    input  logic [WIDTH-1:0]   i_wr_data,
    output logic               o_wr_ready,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic               o_rsp_hit,
    output logic [IDX_W-1:0]   o_rsp_index,
    output logic [WIDTH-1:0]   o_rsp_data,
    output logic               o_rsp_last,
    output logic [IDX_W:0]     o_rsp_count
);
    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_words [WORDS];
    logic [2*WIDTH-1:0] r_ml;
    logic [WORDS-1:0]   r_tag, w_tag;
    logic [IDX_W:0]     r_count, w_count;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any, w_single, w_done;

    capp_priority_encoder #(.N(WORDS), .IDX_W(IDX_W)) u_pe (
        .i_vec    (r_tag),
        .o_idx    (w_idx),
        .o_any    (w_any),
        .o_single (w_single)
    );

    // a bit mismatches if its pair requires 1 and it is 0, or requires 0 and it is 1
    always_comb begin
        w_tag   = '1;
        w_count = '0;
        for (int w = 0; w < WORDS; w++) begin
            for (int i = 0; i < WIDTH; i++)
                w_tag[w] = w_tag[w] & ~(r_ml[2*i+ML_ONE] & ~r_words[w][i])
                                    & ~(r_ml[2*i+ML_ZERO] & r_words[w][i]);
            w_count = w_count + (IDX_W+1)'(w_tag[w]);
        end
    end

    // the beat being accepted is the final one: single responder or the no-match beat
    assign w_done = i_rsp_ready && (w_single || !w_any);

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = i_search_valid ? COMPARE : IDLE;
            COMPARE: w_next = RESP;
            RESP:    w_next = w_done ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int w = 0; w < WORDS; w++) r_words[w] <= '0;
            r_ml    <= '0;
            r_tag   <= '0;
            r_count <= '0;
        end else begin
            if (r_state == IDLE && i_wr_en) r_words[i_wr_addr] <= i_wr_data;
            if (r_state == IDLE && i_search_valid) r_ml <= i_match_lines;
            if (r_state == COMPARE) begin
                r_tag   <= w_tag;
                r_count <= w_count;
            end
            if (r_state == RESP && i_rsp_ready && w_any) r_tag[w_idx] <= 1'b0;
        end
    end

    assign o_search_ready = (r_state == IDLE);
    assign o_wr_ready     = o_search_ready;
    assign o_rsp_valid    = (r_state == RESP);
    assign o_rsp_hit      = o_rsp_valid && w_any;
    assign o_rsp_index    = o_rsp_hit ? w_idx : '0;
    assign o_rsp_data     = o_rsp_hit ? r_words[w_idx] : '0;
    assign o_rsp_last     = o_rsp_valid && (w_single || !w_any);
    assign o_rsp_count    = r_count;
endmodule

// File: tb/tb_capp_word_array.sv
// tb_capp_word_array: directed scoreboard bench for capp_word_array
module tb_capp_word_array;
    import capp_pkg::*;
    localparam int W  = CAPP_WIDTH;
    localparam int N  = CAPP_WORDS;
    localparam int IW = CAPP_IDX_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2*W-1:0] match_lines;
    logic          search_valid, search_ready;
    logic          wr_en, wr_ready;
    logic [IW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          rsp_valid, rsp_ready, rsp_hit, rsp_last;
    logic [IW-1:0] rsp_index;
    logic [W-1:0]  rsp_data;
    logic [IW:0]   rsp_count;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        logic         hit;
        logic         last;
        int           count;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] mem [N];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    capp_word_array dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_match_lines  (match_lines),
        .i_search_valid (search_valid),
        .o_search_ready (search_ready),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .o_wr_ready     (wr_ready),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_hit      (rsp_hit),
        .o_rsp_index    (rsp_index),
        .o_rsp_data     (rsp_data),
        .o_rsp_last     (rsp_last),
        .o_rsp_count    (rsp_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] ml_exact(input logic [W-1:0] val, input logic [W-1:0] mask);
        ml_exact = '0;
        for (int i = 0; i < W; i++)
            if (mask[i]) ml_exact[2*i + (val[i] ? 0 : 1)] = 1'b1;
    endfunction

    // reference: pair 01 needs a 1, 10 needs a 0, 11 never matches, 00 is don't-care
    task automatic model(input logic [2*W-1:0] ml);
        int hits[$];
        for (int w = 0; w < N; w++) begin
            bit ok = 1'b1;
            for (int i = 0; i < W; i++)
                case ({ml[2*i+1], ml[2*i]})
                    2'b01:   if (!mem[w][i]) ok = 1'b0;
                    2'b10:   if (mem[w][i]) ok = 1'b0;
                    2'b11:   ok = 1'b0;
                    default: ;
                endcase
            if (ok) hits.push_back(w);
        end
        if (hits.size() == 0)
            q.push_back('{idx: 0, data: '0, hit: 1'b0, last: 1'b1, count: 0});
        else
            foreach (hits[k])
                q.push_back('{idx: hits[k], data: mem[hits[k]], hit: 1'b1,
                              last: (k == hits.size() - 1), count: hits.size()});
    endtask

    task automatic check_beat(input string tag, input beat_t e);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_hit"},   64'(rsp_hit),   64'(e.hit));
        chk({tag, "_index"}, 64'(rsp_index), 64'(e.idx));
        chk({tag, "_data"},  64'(rsp_data),  64'(e.data));
        chk({tag, "_last"},  64'(rsp_last),  64'(e.last));
        chk({tag, "_count"}, 64'(rsp_count), 64'(e.count));
    endtask

    task automatic write(input logic [IW-1:0] a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        mem[a]  = d;
        cyc();
        wr_en = 1'b0;
    endtask

    // optional write alongside the search request; optional ready hold with a blocked write
    task automatic search(input logic [2*W-1:0] ml, input int hold, input bit do_wr,
                          input logic [IW-1:0] wa, input logic [W-1:0] wd);
        beat_t e;
        if (do_wr) begin
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
            mem[wa] = wd;
        end
        model(ml);
        chk("idle_search_ready", 64'(search_ready), 64'd1);
        chk("idle_wr_ready", 64'(wr_ready), 64'd1);
        match_lines  = ml;
        search_valid = 1'b1;
        cyc();
        search_valid = 1'b0;
        wr_en        = 1'b0;
        chk("compare_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("compare_search_ready", 64'(search_ready), 64'd0);
        cyc();
        if (hold > 0) begin
            rsp_ready = 1'b0;
            e = q[0];
            repeat (hold) begin
                check_beat("hold", e);
                chk("hold_wr_ready", 64'(wr_ready), 64'd0);
                wr_en   = 1'b1;
                wr_addr = 4'd3;
                wr_data = 32'h1234_5678;
                cyc();
            end
            wr_en     = 1'b0;
            rsp_ready = 1'b1;
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            check_beat("beat", e);
            cyc();
        end
        chk("end_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("end_search_ready", 64'(search_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t e;
        rst_n        = 1'b0;
        match_lines  = '0;
        search_valid = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        rsp_ready    = 1'b1;
        for (int w = 0; w < N; w++) mem[w] = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_search_ready", 64'(search_ready), 64'd1);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_rsp_count", 64'(rsp_count), 64'd0);
        chk("rst_rsp_hit", 64'(rsp_hit), 64'd0);
        chk("rst_rsp_index", 64'(rsp_index), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_last", 64'(rsp_last), 64'd0);
        // all don't-care: every word responds
        search('0, 0, 1'b0, '0, '0);
        // exact low half 0xBEEF; word5 is written in the same cycle as the search
        write(4'd3, 32'hDEAD_BEEF);
        write(4'd9, 32'h0000_BEEF);
        search(ml_exact(32'h0000_BEEF, 32'h0000_FFFF), 0, 1'b1, 4'd5, 32'h0000_BEEF);
        // bit31 must be 1: only word3
        search(ml_exact(32'h8000_0000, 32'h8000_0000), 0, 1'b0, '0, '0);
        // pair 11 on bit0: no-match beat
        search(64'd3, 0, 1'b0, '0, '0);
        // backpressure on the first beat with a write attempted during RESP
        search('0, 5, 1'b0, '0, '0);
        search(ml_exact(32'h8000_0000, 32'h8000_0000), 0, 1'b0, '0, '0);
        // reset in the middle of a response stream
        model('0);
        match_lines  = '0;
        search_valid = 1'b1;
        cyc();
        search_valid = 1'b0;
        cyc();
        e = q.pop_front();
        check_beat("prerst", e);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        q.delete();
        for (int w = 0; w < N; w++) mem[w] = '0;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_search_ready", 64'(search_ready), 64'd1);
        chk("midrst_rsp_count", 64'(rsp_count), 64'd0);
        search('0, 0, 1'b0, '0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
